// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined four-operation ALU (shift, add, neg, abs)
// with optional saturation, carry/zero flags, valid/ready handshake on both
// sides and a delivered-result counter.
module alu_pipe #(
   parameter int WIDTH    = 6,
   parameter int SATURATE = 0,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       op_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             cout,
   output logic             zero,
   output logic [CNT_W-1:0] res_count
);

   localparam int STAGES = 2;
   // Intermediate width: large enough that no op loses its overflow bits.
   localparam int IW     = WIDTH + 3;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [1:0]       op;
   } req_t;

   typedef struct packed {
      logic [WIDTH-1:0] out;
      logic             cout;
      logic             zero;
   } resp_t;

   logic [STAGES:1] vld_pipe;   // [1] = s1 valid, [2] = out_valid
   req_t            s1;
   resp_t           s2;
   resp_t           nxt;
   req_t            in_req;
   logic            advance;

   logic [IW-1:0]   a_x, b_x;
   logic [IW-1:0]   r_shift, r_add, r_diff, r_abs, r_sel;
   logic [WIDTH-1:0] r_neg;

   assign in_req    = '{a: A, b: B, op: op_code};
   assign out_valid = vld_pipe[2];
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;
   assign out       = s2.out;
   assign cout      = s2.cout;
   assign zero      = s2.zero;

   // Zero-extended operands and the four candidate results, all unsigned.
   assign a_x     = IW'(s1.a);
   assign b_x     = IW'(s1.b);
   assign r_shift = (a_x << 2) + (b_x >> 1);
   assign r_add   = a_x + (b_x << 1) + b_x;
   assign r_neg   = WIDTH'(0) - s1.b;
   // 2A - B as a two's complement value; the sign bit selects negation.
   assign r_diff  = (a_x << 1) - b_x;
   assign r_abs   = r_diff[IW-1] ? (IW'(0) - r_diff) : r_diff;

   // Select the operation result, derive carry, apply saturation, then zero.
   always_comb begin
      r_sel    = '0;
      nxt      = '0;
      unique case (s1.op)
         2'b00:   r_sel = r_shift;
         2'b01:   r_sel = r_add;
         2'b10:   r_sel = {3'b000, r_neg};
         default: r_sel = r_abs;
      endcase
      nxt.cout = |r_sel[IW-1:WIDTH];
      nxt.out  = r_sel[WIDTH-1:0];
      // Only shift/add clamp; neg and abs always report the wrapped value.
      if (SATURATE != 0 && !s1.op[1] && nxt.cout)
         nxt.out = '1;
      nxt.zero = (nxt.out == '0);
   end

   // Both stages move together on advance and hold everything on a stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s1       <= '0;
         s2       <= '{out: '0, cout: 1'b0, zero: 1'b1};
      end else if (advance) begin
         vld_pipe <= {vld_pipe[1], in_valid};
         s1       <= in_req;
         s2       <= nxt;
      end
   end

   // Count delivered results; wraps naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (!rst_n)
         res_count <= '0;
      else if (out_valid && out_ready)
         res_count <= res_count + 1'b1;
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: three instances share the input stream
// (wrap, saturating, and 3-bit counter variants) and each test task checks
// its own expected values inline.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, out_ready;
   logic [5:0]  A, B;
   logic [1:0]  op_code;

   logic        in_ready, out_valid, cout, zero;
   logic [5:0]  out;
   logic [15:0] res_count;

   logic        s_in_ready, s_out_valid, s_cout, s_zero;
   logic [5:0]  s_out;
   logic [15:0] s_res_count;

   logic        c_in_ready, c_out_valid, c_cout, c_zero;
   logic [5:0]  c_out;
   logic [2:0]  c_res_count;

   int checks   = 0;
   int failures = 0;

   alu_pipe #(.WIDTH(6), .SATURATE(0), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .op_code(op_code), .out_valid(out_valid),
      .out_ready(out_ready), .out(out), .cout(cout), .zero(zero),
      .res_count(res_count));

   alu_pipe #(.WIDTH(6), .SATURATE(1), .CNT_W(16)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .A(A), .B(B), .op_code(op_code), .out_valid(s_out_valid),
      .out_ready(out_ready), .out(s_out), .cout(s_cout), .zero(s_zero),
      .res_count(s_res_count));

   alu_pipe #(.WIDTH(6), .SATURATE(0), .CNT_W(3)) u_cnt (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
      .A(A), .B(B), .op_code(op_code), .out_valid(c_out_valid),
      .out_ready(out_ready), .out(c_out), .cout(c_cout), .zero(c_zero),
      .res_count(c_res_count));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      tick();
      rst_n    = 1'b1;
   endtask

   // Offer one beat, then wait until it reaches the output (out_ready=1).
   task automatic send_one(input logic [1:0] op, input logic [5:0] a, input logic [5:0] b);
      op_code  = op;
      A        = a;
      B        = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A = '0; B = '0; op_code = '0;
      tick();
      tick();
      checks++;
      if ({out_valid, cout, zero, out} !== {1'b0, 1'b0, 1'b1, 6'd0}) begin
         failures++;
         $display("FAIL reset_state got v/c/z/out=%b/%b/%b/%0d exp 0/0/1/0", out_valid, cout, zero, out);
      end
      checks++;
      if (res_count !== 16'd0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_cnt_ready got cnt=%0d rdy=%b exp cnt=0 rdy=1", res_count, in_ready);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL post_reset got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_ops;
      logic [1:0] t_op [6] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
      logic [5:0] t_a  [6] = '{6'd20, 6'd10, 6'd0,  6'd0, 6'd3,  6'd63};
      logic [5:0] t_b  [6] = '{6'd9,  6'd20, 6'd5,  6'd0, 6'd20, 6'd0};
      logic [5:0] t_o  [6] = '{6'd20, 6'd6,  6'd59, 6'd0, 6'd14, 6'd62};
      logic       t_c  [6] = '{1'b1,  1'b1,  1'b0,  1'b0, 1'b0,  1'b1};
      for (int i = 0; i < 6; i++) begin
         send_one(t_op[i], t_a[i], t_b[i]);
         checks++;
         if ({out_valid, cout, zero, out} !== {1'b1, t_c[i], (t_o[i] == 6'd0), t_o[i]}) begin
            failures++;
            $display("FAIL op%0d_vec%0d got v/c/z/out=%b/%b/%b/%0d exp 1/%b/%b/%0d",
                     t_op[i], i, out_valid, cout, zero, out, t_c[i], (t_o[i] == 6'd0), t_o[i]);
         end
      end
   endtask

   task automatic test_saturate;
      send_one(2'b00, 6'd20, 6'd9);
      checks++;
      if ({s_out_valid, s_cout, s_zero, s_out} !== {1'b1, 1'b1, 1'b0, 6'd63}) begin
         failures++;
         $display("FAIL sat_shift got c/z/out=%b/%b/%0d exp 1/0/63", s_cout, s_zero, s_out);
      end
      checks++;
      if (out !== 6'd20) begin
         failures++;
         $display("FAIL wrap_shift got out=%0d exp 20", out);
      end
      send_one(2'b01, 6'd5, 6'd3);
      checks++;
      if ({s_out_valid, s_cout, s_zero, s_out} !== {1'b1, 1'b0, 1'b0, 6'd14}) begin
         failures++;
         $display("FAIL sat_add_noovf got c/z/out=%b/%b/%0d exp 0/0/14", s_cout, s_zero, s_out);
      end
   endtask

   task automatic test_back_to_back;
      logic [1:0] t_op [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10};
      logic [5:0] t_a  [8] = '{6'd1,  6'd7,  6'd0,  6'd10, 6'd63, 6'd63, 6'd0,  6'd0};
      logic [5:0] t_b  [8] = '{6'd2,  6'd3,  6'd1,  6'd5,  6'd63, 6'd63, 6'd63, 6'd0};
      logic [5:0] e_o  [8] = '{6'd5,  6'd16, 6'd63, 6'd15, 6'd27, 6'd60, 6'd63, 6'd0};
      logic       e_c  [8] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
      logic       pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int   sent = 0;
      int   got  = 0;
      logic mv1  = 1'b0;
      logic mv2  = 1'b0;
      logic exp_rdy;
      do_reset();
      for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
         out_ready = pat[cyc % 4];
         in_valid  = (sent < 8);
         if (sent < 8) begin
            op_code = t_op[sent];
            A       = t_a[sent];
            B       = t_b[sent];
         end
         #1;
         exp_rdy = !mv2 || out_ready;
         checks++;
         if (out_valid !== mv2 || in_ready !== exp_rdy) begin
            failures++;
            $display("FAIL stream_hs cyc%0d got v=%b rdy=%b exp v=%b rdy=%b", cyc, out_valid, in_ready, mv2, exp_rdy);
         end
         if (mv2) begin
            checks++;
            if ({cout, zero, out} !== {e_c[got], (e_o[got] == 6'd0), e_o[got]}) begin
               failures++;
               $display("FAIL stream_beat%0d got c/z/out=%b/%b/%0d exp %b/%b/%0d",
                        got, cout, zero, out, e_c[got], (e_o[got] == 6'd0), e_o[got]);
            end
            if (out_ready) got++;
         end
         if (exp_rdy) begin
            if (in_valid) sent++;
            mv2 = mv1;
            mv1 = in_valid;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (got != 8) begin
         failures++;
         $display("FAIL stream_timeout got delivered=%0d exp 8", got);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++;
      if (res_count !== 16'd8 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL stream_count got cnt=%0d v=%b exp cnt=8 v=0", res_count, out_valid);
      end
   endtask

   task automatic test_reset_midstream;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op_code = 2'b01; A = 6'd1; B = 6'd1;
      tick();
      A = 6'd2; B = 6'd2;
      tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if ({out_valid, cout, zero, out, in_ready} !== {1'b0, 1'b0, 1'b1, 6'd0, 1'b1} || res_count !== 16'd0) begin
         failures++;
         $display("FAIL midreset_state got v/c/z/out/rdy=%b/%b/%b/%0d/%b cnt=%0d exp 0/0/1/0/1 cnt=0",
                  out_valid, cout, zero, out, in_ready, res_count);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_discard got v=%b exp 0", out_valid);
      end
      op_code = 2'b00; A = 6'd3; B = 6'd4;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_early got v=%b exp 0", out_valid);
      end
      tick();
      checks++;
      if ({out_valid, cout, zero, out} !== {1'b1, 1'b0, 1'b0, 6'd14}) begin
         failures++;
         $display("FAIL midreset_latency got v/c/z/out=%b/%b/%b/%0d exp 1/0/0/14", out_valid, cout, zero, out);
      end
   endtask

   task automatic test_count_wrap;
      do_reset();
      out_ready = 1'b1;
      op_code = 2'b01; A = 6'd1; B = 6'd0;
      in_valid = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (c_res_count !== 3'd1) begin
         failures++;
         $display("FAIL cnt_wrap got cnt=%0d exp 1", c_res_count);
      end
      checks++;
      if (res_count !== 16'd9) begin
         failures++;
         $display("FAIL cnt_nowrap got cnt=%0d exp 9", res_count);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ops();
      test_saturate();
      test_back_to_back();
      test_reset_midstream();
      test_count_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor of the 6-bit four-operation ALU. It computes the same operation set at any operand width, with optional saturation, status flags, a valid/ready handshake on both sides and a delivered-result counter. Two register stages sit between the operand source and the result consumer. Throughput is one operation per cycle under backpressure.

## Interface
- WIDTH, 6: operand/result width in bits; ≥ 4.
- SATURATE, 0: 1 means op 00/01 overflow clamps out to 2^WIDTH−1; 0 means wrap.
- CNT_W, 16: width of the delivered-result counter.
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising clk edge.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block accepts the beat this cycle.
- A  in  WIDTH  unsigned operand A.
- B  in  WIDTH  unsigned operand B.
- op_code  in  2  00 shift, 01 add, 10 neg, 11 abs.
- out_valid  out  1  result beat offered.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  result.
- cout  out  1  overflow/carry indication for the result.
- zero  out  1  out == 0.
- res_count  out  CNT_W  number of results delivered (out_valid & out_ready) since reset; wraps modulo 2^CNT_W.

## Operation
- Input fire: in_valid & in_ready. Output fire: out_valid & out_ready.
- Arithmetic: all intermediates are unsigned, WIDTH+3 bits wide, and overflow is never lost.
  - 00 shift: r = (A<<2) + (B>>1); cout = (r ≥ 2^WIDTH).
  - 01 add: r = A + 3·B; cout = (r ≥ 2^WIDTH).
  - 10 neg: out = (2^WIDTH − B) mod 2^WIDTH; cout = 0; no saturation.
  - 11 abs: d = 2·A − B, signed, WIDTH+3 bits; m = |d|; out = m mod 2^WIDTH; cout = (m ≥ 2^WIDTH); no saturation.
- For ops 00/01: out = r mod 2^WIDTH when SATURATE=0. When SATURATE=1 and cout=1, out = all ones; cout is still reported as 1.
- zero is computed on the final out, after saturation.
- Stage 1 (s1) registers A, B, op_code and s1_valid.
- Stage 2 (s2) registers out, cout, zero and out_valid; the operation is computed combinationally from s1.
- Pipeline control: advance = !out_valid | out_ready; in_ready = advance.
  - On advance: s2 ← f(s1), out_valid ← s1_valid; s1 ← input with s1_valid ← in_valid.
  - When advance is low, both stages hold all contents.
- res_count increments by 1 on every output fire.

## Timing
- Latency: a beat accepted on edge k is presented at out/out_valid after edge k+1, provided the pipeline is not stalled.
- Throughput: one beat per cycle while out_ready=1.
- in_ready is combinational from out_valid and out_ready; no other combinational input-to-output paths exist.
- Stall, out_valid=1 and out_ready=0:
  - in_ready=0; s1 and s2 hold.
  - out, cout and zero are stable until the output fires.
- A bubble (s1_valid=0) moves into s2 on advance, so out_valid=0 the following cycle.
- Simultaneous output fire and input fire in the same cycle is legal and loses no beat.
- Reset (rst_n=0 at an edge) clears the following; mid-stream reset discards in-flight beats without delivering them:
  - s1_valid=0, out_valid=0.
  - out=0, cout=0, zero=1.
  - res_count=0; s1 operand registers cleared to 0.
- in_ready is 1 during reset and immediately after it.
- res_count at 2^CNT_W−1 followed by an output fire gives 0.

## Test plan
- WIDTH=6, SATURATE=0, out_ready=1: op 00, A=20, B=9 -> two edges later out=20, cout=1, zero=0. Op 01, A=10, B=20 -> out=6, cout=1.
- WIDTH=6: op 10, B=5 -> out=59, cout=0. Op 10, B=0 -> out=0, zero=1. Op 11, A=3, B=20 -> out=14, cout=0. Op 11, A=63, B=0 -> out=62, cout=1.
- WIDTH=6, SATURATE=1: op 00, A=20, B=9 -> out=63, cout=1. Op 01, A=5, B=3 -> out=14, cout=0.
- Streaming with backpressure: 8 back-to-back beats, out_ready toggling 1,0,0,1… -> every beat appears exactly once, in order, with correct results. in_ready=0 exactly on stalled cycles. res_count=8 at the end.
- Reset mid-stream: 2 beats in flight, rst_n=0 for one edge -> out_valid=0, out=0, zero=1, res_count=0. The next beat accepted has latency 2 with correct result.
- CNT_W=3: 9 delivered results -> res_count=1 (wraps at 8).
